joypad_debounce: RTL and testbench
==================================

# joypad_debounce

Debounces the eight Game Boy joypad buttons after the button synchronizer stage and produces the clean state the rest of the design consumes. Its inputs are already synchronized to Clk, with no metastability handling here. Outputs are a stable button vector, single-cycle press/release pulses, the active-low P1 (FF00) input nibble for the selected button group, and the joypad interrupt request pulse for the interrupt controller.

## Interface
- DEBOUNCE_CYCLES, default 65536: consecutive cycles an input must differ from the stable state before the state changes; legal range ≥ 2.
- CNT_W, default $clog2(DEBOUNCE_CYCLES): per-button counter width.
- Clk  input  1  system clock; all state is on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- btn_sync  input  8  synchronized buttons, 1 = pressed; bit map 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.
- sel_dir_n  input  1  P1 bit 4 as written by the CPU; 0 selects the direction group.
- sel_act_n  input  1  P1 bit 5 as written by the CPU; 0 selects the action group.
- btn_state  output  8  debounced state, 1 = pressed.
- press_pulse  output  8  one-cycle pulse per button on a debounced 0→1 transition.
- release_pulse  output  8  one-cycle pulse per button on a debounced 1→0 transition.
- p1_low  output  4  registered active-low P1 bits 3:0.
- joypad_irq  output  1  one-cycle pulse when any p1_low bit falls 1→0.

## Operation
- Per button i: stable bit s[i] (drives btn_state[i]) and counter c[i].
- Each cycle, if btn_sync[i] == s[i]: c[i] <= 0. This means any bounce back to the stable value restarts the count.
- Otherwise, if c[i] == DEBOUNCE_CYCLES-1: s[i] <= btn_sync[i], c[i] <= 0, and the matching pulse (press if the new value is 1, release if 0) is asserted the cycle s[i] changes.
- Otherwise: c[i] <= c[i]+1.
- Counters never wrap, because they are cleared at DEBOUNCE_CYCLES-1.
- Buttons are fully independent. Simultaneous transitions on several buttons yield simultaneous pulses on each.
- P1 nibble, where k = 0..3, computed from btn_state and the selects, then registered:
  - p1_low[k] <= ~((~sel_dir_n & s[k]) | (~sel_act_n & s[k+4])).
  - Both selects low: the groups are ANDed, active-low.
  - Both selects high: 4'hF.
- IRQ: joypad_irq <= |(p1_prev & ~p1_next), where p1_prev is the current p1_low and p1_next is the value being loaded.
  - A select change that exposes an already-pressed button also falls a line and therefore also raises the IRQ. This matches hardware.
- Reset_n low, asynchronously and at any time including mid-count: all s = 0, all c = 0, press_pulse = release_pulse = 0, p1_low = 4'hF, joypad_irq = 0.
- A button held through reset release is treated as a new press. It debounces for DEBOUNCE_CYCLES and then pulses normally.

## Timing
- Input change at cycle 0, held stable:
  - s/btn_state and the pulse change at the rising edge ending cycle DEBOUNCE_CYCLES-1.
  - They are visible during cycle DEBOUNCE_CYCLES.
- Pulses are high exactly one cycle and are coincident with the btn_state update.
- p1_low lags btn_state or select changes by 1 cycle.
- joypad_irq is coincident with the p1_low falling edge, which is 1 cycle after the cause.
- Press to IRQ: DEBOUNCE_CYCLES+1 cycles.
- No handshakes. Consumers sample pulses every cycle.

## Test plan
Use DEBOUNCE_CYCLES=4 throughout.
- **Reset values:** assert Reset_n=0 mid-simulation while a counter is at 2 → btn_state=0, pulses=0, p1_low=4'hF, joypad_irq=0 immediately (no clock needed). After release, a held button needs a fresh 4 cycles.
- **Clean press and release:** raise btn_sync[4] (A) for 10 cycles, then drop it.
  - btn_state[4]=1 and press_pulse[4]=1 visible in cycle 4 only.
  - release_pulse[4] is high exactly 4 cycles after the drop.
  - No other bits toggle.
- **Bounce rejection:** btn_sync[0] pattern 1,1,1,0,1,1,1,1 → the counter restarts at the 0. btn_state[0] rises 4 cycles after the final run begins, and 3-cycle glitches never change state.
- **P1 group select:**
  - Right and Start pressed (debounced), sel_dir_n=0, sel_act_n=1 → p1_low=4'b1110.
  - Swap to sel_dir_n=1, sel_act_n=0 → 4'b0111 one cycle later, with joypad_irq pulse.
  - Both selects high → 4'hF, no IRQ.
- **Interrupt generation:** sel_act_n=0, press B → joypad_irq high exactly one cycle, 5 cycles after the input rose, when p1_low[1] falls. Releasing B produces no IRQ.
- **Simultaneous events:** press all 8 buttons in the same cycle → btn_state=8'hFF and press_pulse=8'hFF in the same single cycle. With both selects low: p1_low=4'h0 and one joypad_irq pulse.

Source files
------------

// File: rtl/joypad_debounce.sv
// ---------------------------------------------------------------------------
// joypad_debounce
// Debounces the eight synchronized joypad buttons. It produces the stable
// button vector, single-cycle press/release pulses, the registered
// active-low P1 input nibble for the selected group(s), and the joypad
// interrupt request pulse.
//
// Ports
//   Clk            system clock, rising edge
//   Reset_n        asynchronous active-low reset
//   btn_sync[7:0]  synchronized buttons, 1 = pressed
//                  (0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start)
//   sel_dir_n      P1 bit 4, 0 selects the direction group
//   sel_act_n      P1 bit 5, 0 selects the action group
//   btn_state      debounced state, 1 = pressed
//   press_pulse    one-cycle pulse on a debounced 0->1 transition
//   release_pulse  one-cycle pulse on a debounced 1->0 transition
//   p1_low[3:0]    registered active-low P1 bits 3:0
//   joypad_irq     one-cycle pulse when any p1_low bit falls
// ---------------------------------------------------------------------------
module joypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] btn_sync,
  input  logic       sel_dir_n,
  input  logic       sel_act_n,
  output logic [7:0] btn_state,
  output logic [7:0] press_pulse,
  output logic [7:0] release_pulse,
  output logic [3:0] p1_low,
  output logic       joypad_irq
);

  localparam int unsigned NUM_BTN = 8;
  localparam int unsigned GRP_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] state_d;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] release_d;
  logic [GRP_W-1:0]   p1_next;
  logic               irq_d;

  // Per-button debounce: any sample equal to the stable value restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = btn_state;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (btn_sync[i] == btn_state[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        state_d[i]   = btn_sync[i];
        cnt_d[i]     = '0;
        press_d[i]   = btn_sync[i];
        release_d[i] = ~btn_sync[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // P1 nibble from the current debounced state; both groups selected AND together.
  always_comb begin
    p1_next = ~((~{GRP_W{sel_dir_n}} & btn_state[GRP_W-1:0]) |
                (~{GRP_W{sel_act_n}} & btn_state[NUM_BTN-1:GRP_W]));
    // Any line falling raises the IRQ, including falls caused by a select change.
    irq_d   = |(p1_low & ~p1_next);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i] <= '0;
      end
      btn_state     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      p1_low        <= '1;
      joypad_irq    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      btn_state     <= state_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      p1_low        <= p1_next;
      joypad_irq    <= irq_d;
    end
  end

endmodule

// File: tb/tb_joypad_debounce.sv
// ---------------------------------------------------------------------------
// tb_joypad_debounce
// Directed bench for joypad_debounce with DEBOUNCE_CYCLES = 4. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_joypad_debounce;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] btn_sync;
  logic       sel_dir_n;
  logic       sel_act_n;
  logic [7:0] btn_state;
  logic [7:0] press_pulse;
  logic [7:0] release_pulse;
  logic [3:0] p1_low;
  logic       joypad_irq;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] pat;

  joypad_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .btn_sync      (btn_sync),
    .sel_dir_n     (sel_dir_n),
    .sel_act_n     (sel_act_n),
    .btn_state     (btn_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .p1_low        (p1_low),
    .joypad_irq    (joypad_irq)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  initial begin
    Reset_n   = 1'b0;
    btn_sync  = 8'h00;
    sel_dir_n = 1'b0;
    sel_act_n = 1'b1;
    repeat (2) tick();
    chk("rst_state", btn_state, 8'h00);
    chk("rst_p1", 8'(p1_low), 8'h0F);
    chk("rst_irq", 8'(joypad_irq), 8'h00);
    Reset_n = 1'b1;

    // Up press with direction group selected
    btn_sync = 8'h04;
    repeat (3) tick();
    chk("up_state_early", btn_state, 8'h00);
    tick();
    chk("up_state", btn_state, 8'h04);
    chk("up_press", press_pulse, 8'h04);
    tick();
    chk("up_press_end", press_pulse, 8'h00);
    chk("up_p1", 8'(p1_low), 8'h0B);
    chk("up_irq", 8'(joypad_irq), 8'h01);
    tick();
    chk("up_irq_end", 8'(joypad_irq), 8'h00);

    // Asynchronous reset while Right's counter sits at 2
    btn_sync = 8'h05;
    repeat (2) tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_state", btn_state, 8'h00);
    chk("arst_press", press_pulse, 8'h00);
    chk("arst_release", release_pulse, 8'h00);
    chk("arst_p1", 8'(p1_low), 8'h0F);
    chk("arst_irq", 8'(joypad_irq), 8'h00);
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    chk("held_state_early", btn_state, 8'h00);
    tick();
    chk("held_state", btn_state, 8'h05);
    chk("held_press", press_pulse, 8'h05);
    tick();
    chk("held_p1", 8'(p1_low), 8'h0A);
    chk("held_irq", 8'(joypad_irq), 8'h01);
    btn_sync = 8'h00;
    repeat (4) tick();
    chk("held_rel_state", btn_state, 8'h00);
    chk("held_release", release_pulse, 8'h05);
    tick();
    chk("held_rel_p1", 8'(p1_low), 8'h0F);
    chk("held_rel_irq", 8'(joypad_irq), 8'h00);

    // Clean press and release of A, no group selected
    sel_dir_n = 1'b1;
    btn_sync  = 8'h10;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("a_state_%0d", k), btn_state, (k >= 4) ? 8'h10 : 8'h00);
      chk($sformatf("a_press_%0d", k), press_pulse, (k == 4) ? 8'h10 : 8'h00);
      chk($sformatf("a_rel_%0d", k), release_pulse, 8'h00);
      chk($sformatf("a_p1_%0d", k), 8'(p1_low), 8'h0F);
    end
    btn_sync = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("a_drop_state_%0d", k), btn_state, (k >= 4) ? 8'h00 : 8'h10);
      chk($sformatf("a_drop_rel_%0d", k), release_pulse, (k == 4) ? 8'h10 : 8'h00);
      chk($sformatf("a_drop_press_%0d", k), press_pulse, 8'h00);
    end

    // Bounce on Right: 1,1,1,0,1,1,1,1
    pat = 8'b1111_0111;
    for (int j = 0; j < 8; j++) begin
      btn_sync = {7'b0, pat[j]};
      tick();
      chk($sformatf("bnc_state_%0d", j), btn_state, (j == 7) ? 8'h01 : 8'h00);
      chk($sformatf("bnc_press_%0d", j), press_pulse, (j == 7) ? 8'h01 : 8'h00);
    end
    btn_sync = 8'h00;
    repeat (4) tick();
    chk("bnc_release", release_pulse, 8'h01);
    tick();

    // Group select with Right and Start held
    sel_dir_n = 1'b0;
    sel_act_n = 1'b1;
    btn_sync  = 8'h81;
    repeat (4) tick();
    chk("sel_state", btn_state, 8'h81);
    tick();
    chk("sel_dir_p1", 8'(p1_low), 8'h0E);
    chk("sel_dir_irq", 8'(joypad_irq), 8'h01);
    tick();
    chk("sel_dir_irq_end", 8'(joypad_irq), 8'h00);
    sel_dir_n = 1'b1;
    sel_act_n = 1'b0;
    tick();
    chk("sel_act_p1", 8'(p1_low), 8'h07);
    chk("sel_act_irq", 8'(joypad_irq), 8'h01);
    tick();
    chk("sel_act_irq_end", 8'(joypad_irq), 8'h00);
    sel_act_n = 1'b1;
    tick();
    chk("sel_none_p1", 8'(p1_low), 8'h0F);
    chk("sel_none_irq", 8'(joypad_irq), 8'h00);
    btn_sync = 8'h00;
    repeat (4) tick();
    chk("sel_release", release_pulse, 8'h81);
    tick();

    // IRQ from B press with action group selected; release gives no IRQ
    sel_act_n = 1'b0;
    btn_sync  = 8'h20;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("b_irq_%0d", k), 8'(joypad_irq), (k == 5) ? 8'h01 : 8'h00);
      if (k == 5) chk("b_p1", 8'(p1_low), 8'h0D);
    end
    btn_sync = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("b_rel_irq_%0d", k), 8'(joypad_irq), 8'h00);
      if (k == 5) chk("b_rel_p1", 8'(p1_low), 8'h0F);
    end

    // All buttons at once, both groups selected
    sel_dir_n = 1'b0;
    btn_sync  = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("all_state_%0d", k), btn_state, (k >= 4) ? 8'hFF : 8'h00);
      chk($sformatf("all_press_%0d", k), press_pulse, (k == 4) ? 8'hFF : 8'h00);
      chk($sformatf("all_irq_%0d", k), 8'(joypad_irq), (k == 5) ? 8'h01 : 8'h00);
      chk($sformatf("all_p1_%0d", k), 8'(p1_low), (k >= 5) ? 8'h00 : 8'h0F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
